// File: rtl/mmio_gpio_controller_pkg.sv
// Shared types and helpers for the MMIO GPIO controller: access sizes,
// register offsets and the load/store data shaping used by the top level.
package mmio_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  // Offsets of the registers that follow the N_OUT output channels.
  function automatic logic [31:0] OFF_IN(input int unsigned n_out);
    return 32'(4 * n_out);
  endfunction

  function automatic logic [31:0] OFF_PEND(input int unsigned n_out);
    return 32'(4 * n_out + 4);
  endfunction

  function automatic logic [31:0] OFF_MASK(input int unsigned n_out);
    return 32'(4 * n_out + 8);
  endfunction

  // RV32 load extension; funct3[2] selects zero extension, size 11 yields 0.
  function automatic logic [31:0] load_extend(input logic [2:0] funct3,
                                              input logic [31:0] word);
    logic sx;
    sx = ~funct3[2];
    case (funct3[1:0])
      SIZE_BYTE: return {{24{sx & word[7]}}, word[7:0]};
      SIZE_HALF: return {{16{sx & word[15]}}, word[15:0]};
      SIZE_WORD: return word;
      default:   return '0;
    endcase
  endfunction

  // Keeps only the bytes covered by the store size.
  function automatic logic [31:0] store_mask(input logic [2:0] funct3,
                                             input logic [31:0] word);
    case (funct3[1:0])
      SIZE_BYTE: return {24'h0, word[7:0]};
      SIZE_HALF: return {16'h0, word[15:0]};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/mmio_gpio_controller_debouncer.sv
// One-bit input conditioner: multi-flop synchroniser followed by a
// debouncer that accepts a new level only after it has held steady.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic stable,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   stable_q;
  logic                   synced;
  logic                   accept;

  assign synced = sync_q[SYNC_STAGES-1];
  assign accept = (synced != stable_q) && (cnt_q == CNT_LAST);
  assign stable = stable_q;
  // Combinational so the pending bit sets on the same edge stable rises.
  assign rise   = accept && synced;

  // Synchroniser shift, debounce counter and accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
      if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_gpio_controller.sv
// Memory-mapped GPIO block between the load/store port and data memory:
// output channels, debounced inputs and a rising-edge interrupt with
// pending/mask registers. Unmapped addresses fall through to memory.
module mmio_gpio_controller
  import mmio_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
  parameter int unsigned N_OUT           = 2,
  parameter int unsigned OUT_WIDTH       = 4,
  parameter int unsigned IN_WIDTH        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       write_enable_i,
  input  logic [2:0]                 funct3_i,
  input  logic [31:0]                address_i,
  input  logic [31:0]                datapath_read_i,
  input  logic [31:0]                memory_read_i,
  input  logic [IN_WIDTH-1:0]        sw_i,
  output logic [N_OUT*OUT_WIDTH-1:0] out_o,
  output logic                       irq_o,
  output logic [31:0]                datapath_write_o
);

  logic [N_OUT-1:0][OUT_WIDTH-1:0] out_q;
  logic [IN_WIDTH-1:0]             pend_q;
  logic [IN_WIDTH-1:0]             mask_q;
  logic                            irq_q;
  logic [IN_WIDTH-1:0]             stable;
  logic [IN_WIDTH-1:0]             rise;

  logic [31:0]      offset;
  logic [N_OUT-1:0] hit_out;
  logic             hit_in;
  logic             hit_pend;
  logic             hit_mask;
  logic             is_reg;
  logic [31:0]      rdata;
  logic [31:0]      wdata;
  logic             wr_ok;

  assign out_o = out_q;
  assign irq_o = irq_q;

  for (genvar g = 0; g < IN_WIDTH; g++) begin : g_in
    input_debouncer #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk   (clk_i),
      .rst   (rst_i),
      .sw    (sw_i[g]),
      .stable(stable[g]),
      .rise  (rise[g])
    );
  end

  // Address decode, register read mux and load data selection.
  always_comb begin
    offset   = address_i - ADDR_BASE;
    hit_out  = '0;
    rdata    = '0;
    hit_in   = (offset == OFF_IN(N_OUT));
    hit_pend = (offset == OFF_PEND(N_OUT));
    hit_mask = (offset == OFF_MASK(N_OUT));
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (offset == 32'(4 * k)) begin
        hit_out[k]             = 1'b1;
        rdata[OUT_WIDTH-1:0]   = out_q[k];
      end
    end
    if (hit_in)   rdata[IN_WIDTH-1:0] = stable;
    if (hit_pend) rdata[IN_WIDTH-1:0] = pend_q;
    if (hit_mask) rdata[IN_WIDTH-1:0] = mask_q;
    is_reg           = (|hit_out) | hit_in | hit_pend | hit_mask;
    datapath_write_o = is_reg ? rdata : load_extend(funct3_i, memory_read_i);
    wdata            = store_mask(funct3_i, datapath_read_i);
    wr_ok            = write_enable_i && (funct3_i[1:0] != 2'b11);
  end

  // Register stores, pending capture with set-over-clear, registered irq.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (wr_ok && hit_out[k]) out_q[k] <= OUT_WIDTH'(wdata);
      end
      if (wr_ok && hit_mask) mask_q <= IN_WIDTH'(wdata);
      if (wr_ok && hit_pend) pend_q <= (pend_q & ~IN_WIDTH'(wdata)) | rise;
      else                   pend_q <= pend_q | rise;
      irq_q <= |(pend_q & mask_q);
    end
  end

endmodule

// File: tb/tb_mmio_gpio_controller.sv
// Directed self-checking bench for mmio_gpio_controller (default parameters).
module tb_mmio_gpio_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        write_enable_i;
  logic [2:0]  funct3_i;
  logic [31:0] address_i;
  logic [31:0] datapath_read_i;
  logic [31:0] memory_read_i;
  logic [3:0]  sw_i;
  logic [7:0]  out_o;
  logic        irq_o;
  logic [31:0] datapath_write_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A_OUT0 = 32'h0;
  localparam logic [31:0] A_OUT1 = 32'h4;
  localparam logic [31:0] A_IN   = 32'h8;
  localparam logic [31:0] A_PEND = 32'hC;
  localparam logic [31:0] A_MASK = 32'h10;

  mmio_gpio_controller #(
    .ADDR_BASE      (32'h0000_0000),
    .N_OUT          (2),
    .OUT_WIDTH      (4),
    .IN_WIDTH       (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .write_enable_i  (write_enable_i),
    .funct3_i        (funct3_i),
    .address_i       (address_i),
    .datapath_read_i (datapath_read_i),
    .memory_read_i   (memory_read_i),
    .sw_i            (sw_i),
    .out_o           (out_o),
    .irq_o           (irq_o),
    .datapath_write_o(datapath_write_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    write_enable_i = 1'b0;
    funct3_i       = 3'b010;
    address_i      = addr;
    #1;
    data = datapath_write_o;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    write_enable_i  = 1'b1;
    funct3_i        = 3'b010;
    address_i       = addr;
    datapath_read_i = data;
    tick();
    write_enable_i  = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;

    //         we    f3      addr     wdata          mem            exp_rd         out
    vecs[0]  = '{1'b0, 3'b000, 32'h100, 32'h0,         32'h0000_0080, 32'hFFFF_FF80, 8'h00};
    vecs[1]  = '{1'b0, 3'b100, 32'h100, 32'h0,         32'h0000_0080, 32'h0000_0080, 8'h00};
    vecs[2]  = '{1'b0, 3'b001, 32'h100, 32'h0,         32'h0000_8001, 32'hFFFF_8001, 8'h00};
    vecs[3]  = '{1'b0, 3'b101, 32'h100, 32'h0,         32'h0000_8001, 32'h0000_8001, 8'h00};
    vecs[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h00};
    vecs[5]  = '{1'b0, 3'b011, 32'h100, 32'h0,         32'hDEAD_BEEF, 32'h0000_0000, 8'h00};
    vecs[6]  = '{1'b1, 3'b000, A_OUT1,  32'h0000_01A5, 32'h0,         32'h0000_0000, 8'h50};
    vecs[7]  = '{1'b0, 3'b000, A_OUT1,  32'h0,         32'h0,         32'h0000_0005, 8'h50};
    vecs[8]  = '{1'b1, 3'b011, A_OUT0,  32'h0000_000F, 32'h0,         32'h0000_0000, 8'h50};
    vecs[9]  = '{1'b1, 3'b010, A_OUT0,  32'hFFFF_FFF3, 32'h0,         32'h0000_0000, 8'h53};
    vecs[10] = '{1'b1, 3'b000, A_OUT1,  32'h0000_008F, 32'h0,         32'h0000_0005, 8'hF3};
    vecs[11] = '{1'b0, 3'b000, A_OUT1,  32'h0,         32'hFFFF_FFFF, 32'h0000_000F, 8'hF3};
    vecs[12] = '{1'b1, 3'b010, A_IN,    32'h0000_000F, 32'h0,         32'h0000_0000, 8'hF3};
    vecs[13] = '{1'b1, 3'b010, 32'h100, 32'h0000_00AA, 32'h0000_0011, 32'h0000_0011, 8'hF3};
    vecs[14] = '{1'b1, 3'b001, A_OUT0,  32'h1234_5676, 32'h0,         32'h0000_0003, 8'hF6};
    vecs[15] = '{1'b1, 3'b000, 32'h2,   32'h0000_0009, 32'h0000_0081, 32'hFFFF_FF81, 8'hF6};
    vecs[16] = '{1'b1, 3'b010, A_MASK,  32'hFFFF_FFF4, 32'h0,         32'h0000_0000, 8'hF6};
    vecs[17] = '{1'b0, 3'b100, A_MASK,  32'h0,         32'h0,         32'h0000_0004, 8'hF6};
    vecs[18] = '{1'b0, 3'b110, 32'h14,  32'h0,         32'h1234_5678, 32'h1234_5678, 8'hF6};
    vecs[19] = '{1'b1, 3'b010, A_PEND,  32'h0000_000F, 32'h0,         32'h0000_0000, 8'hF6};

    rst_i = 1'b1; write_enable_i = 1'b0; funct3_i = 3'b010; address_i = '0;
    datapath_read_i = '0; memory_read_i = '0; sw_i = '0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    check("reset_out", {24'h0, out_o}, 32'h0);
    check("reset_irq", {31'h0, irq_o}, 32'h0);
    read_reg(A_IN, rd);
    check("reset_in", rd, 32'h0);

    // Table-driven register and memory accesses
    for (int i = 0; i < 20; i++) begin
      write_enable_i  = vecs[i].we;
      funct3_i        = vecs[i].f3;
      address_i       = vecs[i].addr;
      datapath_read_i = vecs[i].wdata;
      memory_read_i   = vecs[i].mem;
      #1;
      check($sformatf("vec%0d_rdata", i), datapath_write_o, vecs[i].exp_rd);
      tick();
      check($sformatf("vec%0d_out", i), {24'h0, out_o}, {24'h0, vecs[i].exp_out});
    end
    write_enable_i = 1'b0;

    // Rising input: IN and PEND update 18 edges later, irq one edge after
    sw_i = 4'h4;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 17) begin
        read_reg(A_IN, rd);   check("rise_in_e17", rd, 32'h0);
        read_reg(A_PEND, rd); check("rise_pend_e17", rd, 32'h0);
      end
      if (e == 18) begin
        read_reg(A_IN, rd);   check("rise_in_e18", rd, 32'h4);
        read_reg(A_PEND, rd); check("rise_pend_e18", rd, 32'h4);
        check("rise_irq_e18", {31'h0, irq_o}, 32'h0);
      end
      if (e == 19) check("rise_irq_e19", {31'h0, irq_o}, 32'h1);
    end

    // Short glitch on bit 0 is rejected
    sw_i = 4'h5;
    repeat (10) tick();
    sw_i = 4'h4;
    repeat (30) tick();
    read_reg(A_IN, rd);   check("glitch_in", rd, 32'h4);
    read_reg(A_PEND, rd); check("glitch_pend", rd, 32'h4);

    // W1C drops PEND now and irq one edge later
    write_reg(A_PEND, 32'h4);
    read_reg(A_PEND, rd); check("w1c_pend", rd, 32'h0);
    check("w1c_irq_hold", {31'h0, irq_o}, 32'h1);
    tick();
    check("w1c_irq_drop", {31'h0, irq_o}, 32'h0);

    // Falling edge does not set PEND
    sw_i = 4'h0;
    repeat (20) tick();
    read_reg(A_IN, rd);   check("fall_in", rd, 32'h0);
    read_reg(A_PEND, rd); check("fall_pend", rd, 32'h0);

    // W1C landing on the same edge as a new rise: set wins
    sw_i = 4'h4;
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 17) begin
        write_enable_i  = 1'b1;
        funct3_i        = 3'b010;
        address_i       = A_PEND;
        datapath_read_i = 32'h4;
      end
    end
    write_enable_i = 1'b0;
    read_reg(A_PEND, rd); check("collide_pend", rd, 32'h4);
    read_reg(A_IN, rd);   check("collide_in", rd, 32'h4);
    tick();
    check("collide_irq", {31'h0, irq_o}, 32'h1);
    write_reg(A_PEND, 32'h4);
    read_reg(A_PEND, rd); check("w1c2_pend", rd, 32'h0);
    tick();
    check("w1c2_irq", {31'h0, irq_o}, 32'h0);

    // Bit 1 rise, unmask, then reset mid-debounce with irq high
    sw_i = 4'h6;
    repeat (18) tick();
    read_reg(A_PEND, rd); check("b1_pend", rd, 32'h2);
    write_reg(A_MASK, 32'h6);
    tick();
    check("b1_irq", {31'h0, irq_o}, 32'h1);
    sw_i = 4'hE;
    repeat (5) tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_irq_now", {31'h0, irq_o}, 32'h0);
    check("rst_out_now", {24'h0, out_o}, 32'h0);
    tick(); tick();
    rst_i = 1'b0;
    read_reg(A_MASK, rd); check("rst_mask", rd, 32'h0);
    read_reg(A_PEND, rd); check("rst_pend", rd, 32'h0);
    read_reg(A_IN, rd);   check("rst_in", rd, 32'h0);
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 17) begin
        read_reg(A_PEND, rd); check("post_rst_pend_e17", rd, 32'h0);
      end
      if (e == 18) begin
        read_reg(A_PEND, rd); check("post_rst_pend_e18", rd, 32'hE);
        read_reg(A_IN, rd);   check("post_rst_in_e18", rd, 32'hE);
      end
      if (e == 19) check("post_rst_irq_masked", {31'h0, irq_o}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
